// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Used by imm_pack, imm_encoder and imm_encoder_if users.
package imm_enc_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_U = 3'd4,
        FMT_R = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OP_REG    = 7'b011_0011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // fmt kept as raw bits so the illegal codes 6/7 survive into the packer
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

    // True when imm[31:lsb] are all copies of the sign bit.
    function automatic logic fits_signed(input logic [31:0] imm, input logic [4:0] lsb);
        logic [31:0] sh_v;
        sh_v = 32'($signed(imm) >>> lsb);
        return (sh_v == 32'h0000_0000) || (sh_v == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle of the instruction encoder.
// master = program generator + memory write side, slave = encoder.
interface imm_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational RV32I field packer: scatters the immediate into the
// selected format and flags immediates the format cannot represent.
module imm_pack
    import imm_enc_pkg::*;
(
    input  req_t        req,
    output logic [31:0] instr,
    output logic        err
);

    // Format-dependent bit scatter and range check
    always_comb begin
        instr = 32'h0000_0000;
        err   = 1'b0;
        case (req.fmt)
            FMT_I: begin
                instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                err   = !fits_signed(req.imm, 5'd11);
            end
            FMT_S: begin
                instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
                err   = !fits_signed(req.imm, 5'd11);
            end
            FMT_B: begin
                instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                         req.imm[4:1], req.imm[11], req.opcode};
                err   = req.imm[0] || !fits_signed(req.imm, 5'd12);
            end
            FMT_J: begin
                instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
                err   = req.imm[0] || !fits_signed(req.imm, 5'd20);
            end
            FMT_U: begin
                instr = {req.imm[31:12], req.rd, req.opcode};
                err   = (req.imm[11:0] != 12'h000);
            end
            FMT_R: begin
                instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
                err   = 1'b0;
            end
            default: begin
                instr = 32'h0000_0000;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage pipelined RV32I instruction encoder with valid/ready on both sides.
// Optional statistics counters are enabled by defining IMM_ENCODER_STATS_EN.
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
`ifdef IMM_ENCODER_STATS_EN
   ,parameter int          CNT_W    = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    imm_encoder_if.slave bus
`ifdef IMM_ENCODER_STATS_EN
   ,output logic [CNT_W-1:0] cnt_ok
   ,output logic [CNT_W-1:0] cnt_err
`endif
);

    req_t        req_s;
    req_t        s1_req_r;
    logic        s1_valid_r;
    logic        s2_adv_s;
    logic        in_ready_s;
    logic [31:0] pack_instr_s;
    logic        pack_err_s;
    logic        out_valid_r;
    logic [31:0] out_instr_r;
    logic        out_err_r;

    assign req_s = '{fmt:    bus.in_fmt,
                     opcode: bus.in_opcode,
                     rd:     bus.in_rd,
                     rs1:    bus.in_rs1,
                     rs2:    bus.in_rs2,
                     funct3: bus.in_funct3,
                     funct7: bus.in_funct7,
                     imm:    bus.in_imm};

    // No skid buffer: in_ready follows out_ready combinationally
    assign s2_adv_s     = !out_valid_r || bus.out_ready;
    assign in_ready_s   = !s1_valid_r || s2_adv_s;
    assign bus.in_ready = in_ready_s;

    // S1: capture the raw request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_req_r   <= {$bits(req_t){1'b0}};
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_req_r <= req_s;
            end
        end
    end

    imm_pack u_pack (
        .req   (s1_req_r),
        .instr (pack_instr_s),
        .err   (pack_err_s)
    );

    // S2: hold packed word; rejected requests become NOP_WORD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_err_r   <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_instr_r <= pack_err_s ? NOP_WORD : pack_instr_s;
                out_err_r   <= pack_err_s;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_err   = out_err_r;

`ifdef IMM_ENCODER_STATS_EN
    logic [CNT_W-1:0] cnt_ok_r;
    logic [CNT_W-1:0] cnt_err_r;

    // Saturating per-outcome counters, stepped on each output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ok_r  <= {CNT_W{1'b0}};
            cnt_err_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && bus.out_ready) begin
            if (out_err_r) begin
                if (cnt_err_r != {CNT_W{1'b1}}) begin
                    cnt_err_r <= cnt_err_r + CNT_W'(1);
                end
            end else if (cnt_ok_r != {CNT_W{1'b1}}) begin
                cnt_ok_r <= cnt_ok_r + CNT_W'(1);
            end
        end
    end

    assign cnt_ok  = cnt_ok_r;
    assign cnt_err = cnt_err_r;
`endif

endmodule
